decode_hazard_stage: RTL and testbench
======================================

# decode_hazard_stage

Parametrised ID stage of the 5-stage MIPS pipeline. It replaces the basic decoder stage with an integrated 2^AWIDTH-entry register file, writeback bypass, load-use hazard detection with stall, branch flush, and a registered ID/EX output with sign- or zero-extended immediates. It sits between the fetch stage (it receives the instruction and returns stall) and the execute stage (it receives EX load info and flush).

## Interface
- AWIDTH, 5, register address width; register file has 2^AWIDTH entries
- DWIDTH, 32, data width
- IWIDTH, 32, instruction width
- IMM_WIDTH, 16, immediate field width; extended to DWIDTH on output

Ports:
- dh_clk  in  1  clock; all state updates on rising edge
- dh_rst  in  1  asynchronous, active-low reset
- dh_i_ce  in  1  decode-slot instruction valid
- dh_i_instr  in  IWIDTH  instruction
- dh_i_flush  in  1  branch taken in EX; kill the decode-slot instruction
- dh_i_wb_we / dh_i_wb_addr / dh_i_wb_data  in  1 / AWIDTH / DWIDTH  writeback port
- dh_i_ex_memread / dh_i_ex_rt  in  1 / AWIDTH  EX-stage load and its destination
- dh_o_stall  out  1  combinational; fetch holds PC and instruction
- dh_o_ce  out  1  ID/EX valid
- dh_o_opcode / dh_o_funct  out  6 / 6  decoded fields
- dh_o_rs_addr / dh_o_rt_addr / dh_o_rd_addr  out  AWIDTH  sources and final destination
- dh_o_data_rs / dh_o_data_rt  out  DWIDTH  operands
- dh_o_imm  out  DWIDTH  extended immediate
- dh_o_reg_wr / dh_o_alu_src / dh_o_branch / dh_o_memread / dh_o_memwrite / dh_o_memtoreg / dh_o_illegal  out  1  control flags

## Operation
- Register file:
  - Write on the rising edge when wb_we=1 and wb_addr≠0.
  - Register 0 always reads 0.
  - Reads are combinational, with bypass: if wb_we=1 and wb_addr equals the read address (≠0), the read returns wb_data in the same cycle.
- Supported opcodes:
  - R-type 0x00: reg_wr=1, rd_addr=instr[15:11], alu_src=0.
  - ADDI 0x08 / SLTI 0x0A: reg_wr=1, rd_addr=rt, alu_src=1, imm sign-extended.
  - ANDI 0x0C / ORI 0x0D: reg_wr=1, rd_addr=rt, alu_src=1, imm zero-extended.
  - LW 0x23: memread=1, memtoreg=1, reg_wr=1, alu_src=1, rd_addr=rt.
  - SW 0x2B: memwrite=1, alu_src=1.
  - BEQ 0x04 / BNE 0x05: branch=1, alu_src=0, imm sign-extended.
  - Any other opcode: illegal=1, all other controls 0, ce=1. The instruction is forwarded so a later stage can trap.
- Source usage:
  - rs is used by every supported opcode.
  - rt is a source only for R-type, SW, BEQ and BNE.
- Load-use hazard: hz = i_ce & ex_memread & (ex_rt≠0) & ((ex_rt==rs) | (ex_rt==rt & rt_used)).
- Stall: dh_o_stall = hz & ~dh_i_flush.
- ID/EX register update on each rising edge, in priority order:
  1. flush → bubble.
  2. hz → bubble.
  3. i_ce=0 → bubble.
  4. Otherwise load the decoded instruction with ce=1.
- A bubble clears every output register to 0.

## Timing
- Reset (async assert): register file and all registered outputs = 0, including dh_o_ce=0. Counters are also cleared when enabled.
- Reset mid-operation discards any in-flight instruction. The first decode happens on the first edge after deassertion.
- Latency: instruction valid at edge N → ID/EX outputs valid after edge N.
- A writeback and a read of the same register in one cycle returns the new value in the ID/EX output at the next edge.
- A stall lasts exactly as long as hz is true; normally that is 1 cycle, because EX advances.
- Flush and hz in the same cycle: flush wins and stall=0.
- ex_rt=0 never stalls.

## Configuration
- DH_PERF_CNT_EN defined:
  - Adds outputs dh_o_stall_cnt and dh_o_flush_cnt (32 bits each).
  - stall_cnt increments on each edge where dh_o_stall=1.
  - flush_cnt increments on each edge where flush=1 and i_ce=1.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- DH_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Writeback $2=5, $3=7, then ADD 0x00430820: next edge gives data_rs=5, data_rt=7, rd_addr=1, reg_wr=1, ce=1, alu_src=0.
- Same-cycle bypass: wb $2=9 together with ADD → data_rs=9. Writing $0 with 0x55 → later reads of $0 give 0.
- ex_memread=1, ex_rt=2, ADD (rs=2) → stall=1 and next output ce=0. Same case with SLTI 0x2824000A (rt=4=ex_rt, rt unused, rs=1) → stall=0.
- flush=1 together with the hazard above → stall=0, next ce=0. Instruction opcode 0x3F → illegal=1, ce=1.
- SLTI imm 0xFFF6 → imm=0xFFFFFFF6. ORI imm 0xFFF6 → imm=0x0000FFF6.
- Assert dh_rst low mid-stream → all outputs 0 immediately, with no clock edge. With DH_PERF_CNT_EN: 3 stall cycles → stall_cnt=3.

Source files
------------

// File: rtl/decode_hazard_stage.sv
// MIPS ID stage: register file with writeback bypass, load-use stall, branch flush, ID/EX register.
// Optional DH_PERF_CNT_EN adds saturating stall/flush event counters.
module decode_hazard_stage #(
  parameter int unsigned AWIDTH    = 5,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned IWIDTH    = 32,
  parameter int unsigned IMM_WIDTH = 16
) (
  input  logic              dh_clk,
  input  logic              dh_rst,
  input  logic              dh_i_ce,
  input  logic [IWIDTH-1:0] dh_i_instr,
  input  logic              dh_i_flush,
  input  logic              dh_i_wb_we,
  input  logic [AWIDTH-1:0] dh_i_wb_addr,
  input  logic [DWIDTH-1:0] dh_i_wb_data,
  input  logic              dh_i_ex_memread,
  input  logic [AWIDTH-1:0] dh_i_ex_rt,
  output logic              dh_o_stall,
  output logic              dh_o_ce,
  output logic [5:0]        dh_o_opcode,
  output logic [5:0]        dh_o_funct,
  output logic [AWIDTH-1:0] dh_o_rs_addr,
  output logic [AWIDTH-1:0] dh_o_rt_addr,
  output logic [AWIDTH-1:0] dh_o_rd_addr,
  output logic [DWIDTH-1:0] dh_o_data_rs,
  output logic [DWIDTH-1:0] dh_o_data_rt,
  output logic [DWIDTH-1:0] dh_o_imm,
  output logic              dh_o_reg_wr,
  output logic              dh_o_alu_src,
  output logic              dh_o_branch,
  output logic              dh_o_memread,
  output logic              dh_o_memwrite,
  output logic              dh_o_memtoreg,
  output logic              dh_o_illegal
`ifdef DH_PERF_CNT_EN
  ,
  output logic [31:0]       dh_o_stall_cnt,
  output logic [31:0]       dh_o_flush_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [DWIDTH-1:0] rf_q [2**AWIDTH];

  logic [5:0]           opcode;
  logic [AWIDTH-1:0]    rs_addr, rt_addr, rd_field;
  logic [IMM_WIDTH-1:0] imm_field;
  logic [DWIDTH-1:0]    data_rs, data_rt, imm_ext;

  assign opcode    = dh_i_instr[31:26];
  assign rs_addr   = dh_i_instr[21 +: AWIDTH];
  assign rt_addr   = dh_i_instr[16 +: AWIDTH];
  assign rd_field  = dh_i_instr[11 +: AWIDTH];
  assign imm_field = dh_i_instr[IMM_WIDTH-1:0];

  always_ff @(posedge dh_clk or negedge dh_rst) begin
    if (!dh_rst) begin
      for (int i = 0; i < 2**AWIDTH; i++) rf_q[i] <= '0;
    end else if (dh_i_wb_we && dh_i_wb_addr != '0) begin
      rf_q[dh_i_wb_addr] <= dh_i_wb_data;
    end
  end

  // Writeback bypass makes a same-cycle write visible to the decode read.
  assign data_rs = (rs_addr == '0) ? '0 :
                   (dh_i_wb_we && dh_i_wb_addr == rs_addr) ? dh_i_wb_data : rf_q[rs_addr];
  assign data_rt = (rt_addr == '0) ? '0 :
                   (dh_i_wb_we && dh_i_wb_addr == rt_addr) ? dh_i_wb_data : rf_q[rt_addr];

  logic              reg_wr, alu_src, branch, memread, memwrite, memtoreg, illegal;
  logic              rt_used, zero_ext;
  logic [AWIDTH-1:0] dest;

  always_comb begin
    reg_wr   = 1'b0;
    alu_src  = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    illegal  = 1'b0;
    rt_used  = 1'b0;
    zero_ext = 1'b0;
    dest     = '0;
    case (opcode)
      OP_RTYPE: begin reg_wr = 1'b1; dest = rd_field; rt_used = 1'b1; end
      OP_ADDI, OP_SLTI: begin reg_wr = 1'b1; dest = rt_addr; alu_src = 1'b1; end
      OP_ANDI, OP_ORI: begin
        reg_wr = 1'b1; dest = rt_addr; alu_src = 1'b1; zero_ext = 1'b1;
      end
      OP_LW: begin
        reg_wr = 1'b1; dest = rt_addr; alu_src = 1'b1; memread = 1'b1; memtoreg = 1'b1;
      end
      OP_SW: begin memwrite = 1'b1; alu_src = 1'b1; rt_used = 1'b1; end
      OP_BEQ, OP_BNE: begin branch = 1'b1; rt_used = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_ext = zero_ext ? {{(DWIDTH-IMM_WIDTH){1'b0}}, imm_field}
                            : {{(DWIDTH-IMM_WIDTH){imm_field[IMM_WIDTH-1]}}, imm_field};

  logic hz, bubble;
  assign hz = dh_i_ce & dh_i_ex_memread & (dh_i_ex_rt != '0) &
              ((dh_i_ex_rt == rs_addr) | ((dh_i_ex_rt == rt_addr) & rt_used));
  assign dh_o_stall = hz & ~dh_i_flush;
  assign bubble     = dh_i_flush | hz | ~dh_i_ce;

  always_ff @(posedge dh_clk or negedge dh_rst) begin
    if (!dh_rst) begin
      dh_o_ce       <= 1'b0;
      dh_o_opcode   <= '0;
      dh_o_funct    <= '0;
      dh_o_rs_addr  <= '0;
      dh_o_rt_addr  <= '0;
      dh_o_rd_addr  <= '0;
      dh_o_data_rs  <= '0;
      dh_o_data_rt  <= '0;
      dh_o_imm      <= '0;
      dh_o_reg_wr   <= 1'b0;
      dh_o_alu_src  <= 1'b0;
      dh_o_branch   <= 1'b0;
      dh_o_memread  <= 1'b0;
      dh_o_memwrite <= 1'b0;
      dh_o_memtoreg <= 1'b0;
      dh_o_illegal  <= 1'b0;
    end else begin
      dh_o_ce       <= ~bubble;
      dh_o_opcode   <= bubble ? '0 : opcode;
      dh_o_funct    <= bubble ? '0 : dh_i_instr[5:0];
      dh_o_rs_addr  <= bubble ? '0 : rs_addr;
      dh_o_rt_addr  <= bubble ? '0 : rt_addr;
      dh_o_rd_addr  <= bubble ? '0 : dest;
      dh_o_data_rs  <= bubble ? '0 : data_rs;
      dh_o_data_rt  <= bubble ? '0 : data_rt;
      dh_o_imm      <= bubble ? '0 : imm_ext;
      dh_o_reg_wr   <= ~bubble & reg_wr;
      dh_o_alu_src  <= ~bubble & alu_src;
      dh_o_branch   <= ~bubble & branch;
      dh_o_memread  <= ~bubble & memread;
      dh_o_memwrite <= ~bubble & memwrite;
      dh_o_memtoreg <= ~bubble & memtoreg;
      dh_o_illegal  <= ~bubble & illegal;
    end
  end

`ifdef DH_PERF_CNT_EN
  always_ff @(posedge dh_clk or negedge dh_rst) begin
    if (!dh_rst) begin
      dh_o_stall_cnt <= '0;
      dh_o_flush_cnt <= '0;
    end else begin
      if (dh_o_stall && dh_o_stall_cnt != 32'hFFFF_FFFF) dh_o_stall_cnt <= dh_o_stall_cnt + 32'd1;
      if (dh_i_flush && dh_i_ce && dh_o_flush_cnt != 32'hFFFF_FFFF) begin
        dh_o_flush_cnt <= dh_o_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Testbench for decode_hazard_stage: directed vector table, hand sequences, random vs reference model.
module tb_decode_hazard_stage;

  logic        dh_clk = 1'b0;
  logic        dh_rst = 1'b0;
  logic        dh_i_ce = 1'b0;
  logic [31:0] dh_i_instr = '0;
  logic        dh_i_flush = 1'b0;
  logic        dh_i_wb_we = 1'b0;
  logic [4:0]  dh_i_wb_addr = '0;
  logic [31:0] dh_i_wb_data = '0;
  logic        dh_i_ex_memread = 1'b0;
  logic [4:0]  dh_i_ex_rt = '0;
  logic        dh_o_stall, dh_o_ce;
  logic [5:0]  dh_o_opcode, dh_o_funct;
  logic [4:0]  dh_o_rs_addr, dh_o_rt_addr, dh_o_rd_addr;
  logic [31:0] dh_o_data_rs, dh_o_data_rt, dh_o_imm;
  logic        dh_o_reg_wr, dh_o_alu_src, dh_o_branch, dh_o_memread;
  logic        dh_o_memwrite, dh_o_memtoreg, dh_o_illegal;
`ifdef DH_PERF_CNT_EN
  logic [31:0] dh_o_stall_cnt, dh_o_flush_cnt;
`endif

  decode_hazard_stage #(.AWIDTH(5), .DWIDTH(32), .IWIDTH(32), .IMM_WIDTH(16)) dut (
    .dh_clk(dh_clk), .dh_rst(dh_rst), .dh_i_ce(dh_i_ce), .dh_i_instr(dh_i_instr),
    .dh_i_flush(dh_i_flush), .dh_i_wb_we(dh_i_wb_we), .dh_i_wb_addr(dh_i_wb_addr),
    .dh_i_wb_data(dh_i_wb_data), .dh_i_ex_memread(dh_i_ex_memread), .dh_i_ex_rt(dh_i_ex_rt),
    .dh_o_stall(dh_o_stall), .dh_o_ce(dh_o_ce), .dh_o_opcode(dh_o_opcode),
    .dh_o_funct(dh_o_funct), .dh_o_rs_addr(dh_o_rs_addr), .dh_o_rt_addr(dh_o_rt_addr),
    .dh_o_rd_addr(dh_o_rd_addr), .dh_o_data_rs(dh_o_data_rs), .dh_o_data_rt(dh_o_data_rt),
    .dh_o_imm(dh_o_imm), .dh_o_reg_wr(dh_o_reg_wr), .dh_o_alu_src(dh_o_alu_src),
    .dh_o_branch(dh_o_branch), .dh_o_memread(dh_o_memread), .dh_o_memwrite(dh_o_memwrite),
    .dh_o_memtoreg(dh_o_memtoreg), .dh_o_illegal(dh_o_illegal)
`ifdef DH_PERF_CNT_EN
    , .dh_o_stall_cnt(dh_o_stall_cnt), .dh_o_flush_cnt(dh_o_flush_cnt)
`endif
  );

  always #5 dh_clk = ~dh_clk;

  typedef struct packed {
    logic ce; logic [31:0] instr; logic flush; logic we; logic [4:0] wa; logic [31:0] wd;
    logic mr; logic [4:0] ert;
  } in_t;

  typedef struct packed {
    logic ce; logic [5:0] op, fn; logic [4:0] rs, rt, rd; logic [31:0] drs, drt, imm;
    logic reg_wr, alu_src, branch, memread, memwrite, memtoreg, illegal;
  } out_t;

  typedef struct {
    in_t in; logic stall, ce, reg_wr, illegal, chk_imm;
    logic [4:0] rd; logic [31:0] drs, drt, imm;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] mregs [32];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic in_t vin(logic ce, logic [31:0] instr, logic flush, logic we,
                              logic [4:0] wa, logic [31:0] wd, logic mr, logic [4:0] ert);
    in_t r;
    r.ce = ce; r.instr = instr; r.flush = flush; r.we = we;
    r.wa = wa; r.wd = wd; r.mr = mr; r.ert = ert;
    return r;
  endfunction

  task automatic add(input in_t i, input logic st, input logic ce, input logic rw,
                     input logic ill, input logic [4:0] rd, input logic [31:0] drs,
                     input logic [31:0] drt, input logic ci, input logic [31:0] imm);
    vec_t t;
    t.in = i; t.stall = st; t.ce = ce; t.reg_wr = rw; t.illegal = ill; t.rd = rd;
    t.drs = drs; t.drt = drt; t.chk_imm = ci; t.imm = imm;
    tbl.push_back(t);
  endtask

  // Drive at negedge, capture stall before the edge, sample outputs 1 time unit after it.
  task automatic cycle(input in_t v, output logic stall_seen);
    @(negedge dh_clk);
    dh_i_ce = v.ce; dh_i_instr = v.instr; dh_i_flush = v.flush; dh_i_wb_we = v.we;
    dh_i_wb_addr = v.wa; dh_i_wb_data = v.wd; dh_i_ex_memread = v.mr; dh_i_ex_rt = v.ert;
    #1;
    stall_seen = dh_o_stall;
    @(posedge dh_clk);
    if (v.we && v.wa != 5'd0) mregs[v.wa] = v.wd;
    #1;
  endtask

  // Reference model: spec rules evaluated directly on the instruction fields.
  function automatic logic model_hz(in_t v);
    logic [5:0] op = v.instr[31:26];
    logic [4:0] rs = v.instr[25:21];
    logic [4:0] rt = v.instr[20:16];
    logic rt_used = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    return v.ce && v.mr && v.ert != 0 && (v.ert == rs || (v.ert == rt && rt_used));
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] a, in_t v);
    if (a == 0) return 32'd0;
    if (v.we && v.wa == a) return v.wd;
    return mregs[a];
  endfunction

  function automatic out_t model_out(in_t v);
    out_t o;
    logic [5:0] op;
    o = '0;
    op = v.instr[31:26];
    if (v.flush || model_hz(v) || !v.ce) return o;
    o.ce = 1; o.op = op; o.fn = v.instr[5:0];
    o.rs = v.instr[25:21]; o.rt = v.instr[20:16];
    o.drs = model_read(o.rs, v); o.drt = model_read(o.rt, v);
    if (op == 6'h0C || op == 6'h0D) o.imm = {16'h0, v.instr[15:0]};
    else o.imm = 32'($signed(v.instr[15:0]));
    case (op)
      6'h00: begin o.reg_wr = 1; o.rd = v.instr[15:11]; end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin o.reg_wr = 1; o.rd = o.rt; o.alu_src = 1; end
      6'h23: begin o.reg_wr = 1; o.rd = o.rt; o.alu_src = 1; o.memread = 1; o.memtoreg = 1; end
      6'h2B: begin o.memwrite = 1; o.alu_src = 1; end
      6'h04, 6'h05: o.branch = 1;
      default: o.illegal = 1;
    endcase
    return o;
  endfunction

  task automatic compare_out(input string tag, input out_t e, input logic [5:0] op);
    chk({tag, " ce"}, dh_o_ce, e.ce);
    chk({tag, " opcode"}, dh_o_opcode, e.op);
    chk({tag, " funct"}, dh_o_funct, e.fn);
    chk({tag, " rs_addr"}, dh_o_rs_addr, e.rs);
    chk({tag, " rt_addr"}, dh_o_rt_addr, e.rt);
    chk({tag, " data_rs"}, dh_o_data_rs, e.drs);
    chk({tag, " data_rt"}, dh_o_data_rt, e.drt);
    chk({tag, " flags"},
        {dh_o_reg_wr, dh_o_alu_src, dh_o_branch, dh_o_memread, dh_o_memwrite,
         dh_o_memtoreg, dh_o_illegal},
        {e.reg_wr, e.alu_src, e.branch, e.memread, e.memwrite, e.memtoreg, e.illegal});
    if (!e.ce || e.reg_wr) chk({tag, " rd_addr"}, dh_o_rd_addr, e.rd);
    if (!e.ce || op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05})
      chk({tag, " imm"}, dh_o_imm, e.imm);
  endtask

  function automatic in_t rand_in();
    in_t r;
    logic [5:0] op;
    logic [4:0] rs, rt;
    case ($urandom_range(0, 10))
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h0A;  3: op = 6'h0C;
      4: op = 6'h0D;  5: op = 6'h23;  6: op = 6'h2B;  7: op = 6'h04;
      8: op = 6'h05;  9: op = 6'h3F;  default: op = 6'($urandom);
    endcase
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    r.instr = {op, rs, rt, 16'($urandom)};
    r.ce = ($urandom_range(0, 3) != 0);
    r.flush = ($urandom_range(0, 7) == 0);
    r.we = $urandom_range(0, 1) == 1;
    r.wa = 5'($urandom_range(0, 7));
    r.wd = $urandom;
    r.mr = ($urandom_range(0, 2) == 0);
    r.ert = 5'($urandom_range(0, 7));
    return r;
  endfunction

  localparam logic [31:0] ADD_1_2_3 = 32'h0043_0820;

  initial begin
    logic st;
    vec_t t;
    in_t v;
    out_t e;
`ifdef DH_PERF_CNT_EN
    logic [31:0] sc0, fc0;
`endif
    foreach (mregs[k]) mregs[k] = '0;

    add(vin(0, 0, 0, 1, 2, 5, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(vin(0, 0, 0, 1, 3, 7, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(vin(1, ADD_1_2_3, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 1, 5, 7, 0, 0);
    add(vin(1, ADD_1_2_3, 0, 1, 2, 9, 0, 0), 0, 1, 1, 0, 1, 9, 7, 0, 0);
    add(vin(1, 32'h0003_0820, 0, 1, 0, 32'h55, 0, 0), 0, 1, 1, 0, 1, 0, 7, 0, 0);
    add(vin(1, 32'h0060_0820, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 1, 7, 0, 0, 0);
    add(vin(1, ADD_1_2_3, 0, 0, 0, 0, 1, 2), 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(vin(1, 32'h2824_000A, 0, 0, 0, 0, 1, 4), 0, 1, 1, 0, 4, 0, 0, 1, 32'hA);
    add(vin(1, ADD_1_2_3, 1, 0, 0, 0, 1, 2), 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(vin(1, 32'hFC00_0000, 0, 0, 0, 0, 0, 0), 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(vin(1, 32'h2824_FFF6, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 4, 0, 0, 1, 32'hFFFF_FFF6);
    add(vin(1, 32'h3424_FFF6, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 4, 0, 0, 1, 32'h0000_FFF6);
    add(vin(1, 32'h0003_0820, 0, 0, 0, 0, 1, 0), 0, 1, 1, 0, 1, 0, 7, 0, 0);
    add(vin(1, 32'h8C44_0004, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 4, 9, 0, 1, 32'h4);
    add(vin(0, ADD_1_2_3, 0, 0, 0, 0, 1, 2), 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(vin(1, 32'hAC43_0000, 0, 0, 0, 0, 1, 3), 1, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset state with no clock edge yet.
    #2;
    chk("reset ce", dh_o_ce, 0);
    chk("reset reg_wr", dh_o_reg_wr, 0);
    chk("reset data_rs", dh_o_data_rs, 0);
`ifdef DH_PERF_CNT_EN
    chk("reset stall_cnt", dh_o_stall_cnt, 0);
`endif
    @(negedge dh_clk);
    dh_rst = 1'b1;

    foreach (tbl[k]) begin
      t = tbl[k];
      cycle(t.in, st);
      chk($sformatf("vec%0d stall", k), st, t.stall);
      chk($sformatf("vec%0d ce", k), dh_o_ce, t.ce);
      chk($sformatf("vec%0d reg_wr", k), dh_o_reg_wr, t.reg_wr);
      chk($sformatf("vec%0d illegal", k), dh_o_illegal, t.illegal);
      chk($sformatf("vec%0d data_rs", k), dh_o_data_rs, t.drs);
      chk($sformatf("vec%0d data_rt", k), dh_o_data_rt, t.drt);
      if (t.reg_wr || !t.ce) chk($sformatf("vec%0d rd_addr", k), dh_o_rd_addr, t.rd);
      if (t.chk_imm) chk($sformatf("vec%0d imm", k), dh_o_imm, t.imm);
    end

    // Load-use held for three cycles, then released.
`ifdef DH_PERF_CNT_EN
    sc0 = dh_o_stall_cnt;
    fc0 = dh_o_flush_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      cycle(vin(1, ADD_1_2_3, 0, 0, 0, 0, 1, 3), st);
      chk($sformatf("hold%0d stall", k), st, 1);
      chk($sformatf("hold%0d ce", k), dh_o_ce, 0);
    end
    cycle(vin(1, ADD_1_2_3, 0, 0, 0, 0, 0, 3), st);
    chk("release stall", st, 0);
    chk("release ce", dh_o_ce, 1);
    chk("release data_rs", dh_o_data_rs, 9);
    cycle(vin(1, ADD_1_2_3, 1, 0, 0, 0, 0, 0), st);
    chk("flush ce", dh_o_ce, 0);
    cycle(vin(0, ADD_1_2_3, 1, 0, 0, 0, 0, 0), st);
    chk("flush idle ce", dh_o_ce, 0);
`ifdef DH_PERF_CNT_EN
    chk("stall_cnt delta", dh_o_stall_cnt - sc0, 3);
    chk("flush_cnt delta", dh_o_flush_cnt - fc0, 1);
`endif

    // Asynchronous reset mid-stream, away from any clock edge.
    cycle(vin(1, ADD_1_2_3, 0, 0, 0, 0, 0, 0), st);
    chk("pre-reset ce", dh_o_ce, 1);
    #2;
    dh_rst = 1'b0;
    #1;
    chk("async rst ce", dh_o_ce, 0);
    chk("async rst data_rs", dh_o_data_rs, 0);
    chk("async rst data_rt", dh_o_data_rt, 0);
    chk("async rst rd/rs/rt", {dh_o_rd_addr, dh_o_rs_addr, dh_o_rt_addr}, 0);
    chk("async rst flags", {dh_o_reg_wr, dh_o_alu_src, dh_o_opcode, dh_o_funct, dh_o_imm}, 0);
`ifdef DH_PERF_CNT_EN
    chk("async rst counters", dh_o_stall_cnt | dh_o_flush_cnt, 0);
`endif
    @(negedge dh_clk);
    dh_rst = 1'b1;
    foreach (mregs[k]) mregs[k] = '0;
    cycle(vin(1, ADD_1_2_3, 0, 0, 0, 0, 0, 0), st);
    chk("post-reset ce", dh_o_ce, 1);
    chk("post-reset rf rs", dh_o_data_rs, 0);
    chk("post-reset rf rt", dh_o_data_rt, 0);

    for (int n = 0; n < 400; n++) begin
      v = rand_in();
      e = model_out(v);
      cycle(v, st);
      chk($sformatf("rnd%0d stall", n), st, v.ce & model_hz(v) & ~v.flush);
      compare_out($sformatf("rnd%0d", n), e, v.instr[31:26]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
